// File: rtl/regfile_pkg.sv
// Shared encodings for the register-file write-back path: load sizes, byte masks, $0 index.
package regfile_pkg;

  localparam int unsigned MASK_W   = 4;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [MASK_W-1:0] MASK_WORD = 4'b1111;
  localparam logic [MASK_W-1:0] MASK_HALF = 4'b0011;
  localparam logic [MASK_W-1:0] MASK_BYTE = 4'b0001;

  // Reserved size writes the full word; the error is flagged separately.
  function automatic logic [MASK_W-1:0] size_to_mask(input logic [1:0] size);
    logic [MASK_W-1:0] mask;
    case (size)
      SZ_HALF: mask = MASK_HALF;
      SZ_BYTE: mask = MASK_BYTE;
      default: mask = MASK_WORD;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = IDX_W'((int'(ptr) + k) % int'(NUM_REQ));
      if (en && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among write-back sources.
// Optional operand forwarding from the output stage is enabled with `define WB_FWD_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_size,
  input  logic                      rf_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [MASK_W-1:0]         rf_wmask,
  output logic                      err_size,
  output logic                      busy
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         fwd_addr_a,
  input  logic [ADDR_W-1:0]         fwd_addr_b,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [2*DATA_W-1:0]       fwd_data
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   next_ptr_c;
  logic [NUM_REQ-1:0] grant;
  logic               free_c;
  logic               accept_c;
  logic               load_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_data_c;
  logic [1:0]         sel_size_c;

  // Stage can take a new write if empty or its current write retires this cycle.
  assign free_c = !rf_we || rf_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .valid  (req_valid),
    .ptr    (ptr),
    .en     (free_c),
    .grant  (grant),
    .winner (winner)
  );

  assign req_ready = grant;
  assign accept_c  = |grant;
  assign busy      = rf_we;

  // Select the granted requester's payload.
  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    sel_size_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
        sel_data_c = req_data[i*DATA_W +: DATA_W];
        sel_size_c = req_size[i*2 +: 2];
      end
    end
  end

  assign next_ptr_c = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(winner + 1'b1);
  assign load_c     = accept_c && (sel_addr_c != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_wmask <= '0;
      err_size <= 1'b0;
    end else begin
      err_size <= accept_c && (sel_size_c == SZ_RSVD);
      if (accept_c) begin
        ptr <= next_ptr_c;
      end
      // $0 transfers are consumed without occupying the stage.
      if (load_c) begin
        rf_we    <= 1'b1;
        rf_waddr <= sel_addr_c;
        rf_wdata <= sel_data_c;
        rf_wmask <= size_to_mask(sel_size_c);
      end else if (rf_ready) begin
        rf_we <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  // Only full-word pending writes can be forwarded; partial writes need the RF merge.
  always_comb begin
    fwd_hit_a = busy && (rf_waddr == fwd_addr_a) && (fwd_addr_a != ADDR_W'(REG_ZERO))
                && (rf_wmask == MASK_WORD);
    fwd_hit_b = busy && (rf_waddr == fwd_addr_b) && (fwd_addr_b != ADDR_W'(REG_ZERO))
                && (rf_wmask == MASK_WORD);
    fwd_data  = '0;
    if (fwd_hit_a) fwd_data[DATA_W-1:0]        = rf_wdata;
    if (fwd_hit_b) fwd_data[2*DATA_W-1:DATA_W] = rf_wdata;
  end
`endif

endmodule
